// File: rtl/ws2812b_reg_arbiter.sv
// ws2812b_reg_arbiter
// Shares the single LED-controller register port between the I2C bridge
// (port 0) and the pattern engine (port 1). A requester can hold ownership
// across transfers (lock) so its COMMAND -> R/G/B sequence stays contiguous.
// A silent controller is detected by a timeout, which completes the transfer
// with error set and read data 8'hFF.

module ws2812b_reg_arbiter #(
  parameter int ADDRESS_WIDTH  = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                     clock,
  input  logic                     resetn,
  // requester port 0 (I2C register bridge)
  input  logic                     req0,
  input  logic                     is_write0,
  input  logic [ADDRESS_WIDTH-1:0] address0,
  input  logic [7:0]               write_data0,
  input  logic                     lock0,
  output logic                     response0,
  output logic [7:0]               read_data0,
  output logic                     error0,
  // requester port 1 (pattern engine)
  input  logic                     req1,
  input  logic                     is_write1,
  input  logic [ADDRESS_WIDTH-1:0] address1,
  input  logic [7:0]               write_data1,
  input  logic                     lock1,
  output logic                     response1,
  output logic [7:0]               read_data1,
  output logic                     error1,
  // downstream LED controller register port
  output logic                     reg_request,
  output logic                     reg_is_write,
  output logic [ADDRESS_WIDTH-1:0] reg_address,
  output logic [7:0]               reg_write_data,
  input  logic                     reg_response,
  input  logic [7:0]               reg_read_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  // One extra bit so the counter can hold TIMEOUT_CYCLES itself.
  localparam int COUNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1) + 1;
  localparam logic [COUNT_WIDTH-1:0] COUNT_LIMIT = COUNT_WIDTH'(TIMEOUT_CYCLES);

  state_t                 state_r;
  logic                   grant_r;        // port currently being served
  logic                   last_grant_r;   // port granted most recently
  logic                   owner_valid_r;  // a port holds the lock
  logic                   owner_r;        // which port holds the lock
  logic [COUNT_WIDTH-1:0] count_r;

  logic req0_ok_s;
  logic req1_ok_s;
  logic grant_valid_s;
  logic grant_port_s;
  logic done_lock_s;

  // Eligible requesters, round-robin winner and the served port's lock request.
  always_comb begin
    req0_ok_s     = req0 && (!owner_valid_r || (owner_r == 1'b0));
    req1_ok_s     = req1 && (!owner_valid_r || (owner_r == 1'b1));
    grant_valid_s = req0_ok_s || req1_ok_s;
    if (req0_ok_s && req1_ok_s) begin
      grant_port_s = ~last_grant_r;
    end else if (req1_ok_s) begin
      grant_port_s = 1'b1;
    end else begin
      grant_port_s = 1'b0;
    end
    if (grant_r) begin
      done_lock_s = lock1;
    end else begin
      done_lock_s = lock0;
    end
  end

  // Arbitration FSM: grant, wait for response or timeout, one-cycle completion.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_r        <= IDLE;
      grant_r        <= 1'b0;
      last_grant_r   <= 1'b1;
      owner_valid_r  <= 1'b0;
      owner_r        <= 1'b0;
      count_r        <= '0;
      reg_request    <= 1'b0;
      reg_is_write   <= 1'b0;
      reg_address    <= '0;
      reg_write_data <= 8'h00;
      response0      <= 1'b0;
      response1      <= 1'b0;
      error0         <= 1'b0;
      error1         <= 1'b0;
      read_data0     <= 8'h00;
      read_data1     <= 8'h00;
    end else begin
      // pulses default low; read data and downstream fields hold
      reg_request <= 1'b0;
      response0   <= 1'b0;
      response1   <= 1'b0;
      error0      <= 1'b0;
      error1      <= 1'b0;
      case (state_r)
        IDLE: begin
          if (grant_valid_s) begin
            grant_r      <= grant_port_s;
            last_grant_r <= grant_port_s;
            reg_request  <= 1'b1;
            if (grant_port_s) begin
              reg_is_write   <= is_write1;
              reg_address    <= address1;
              reg_write_data <= write_data1;
            end else begin
              reg_is_write   <= is_write0;
              reg_address    <= address0;
              reg_write_data <= write_data0;
            end
            count_r <= '0;
            state_r <= WAIT;
          end else begin
            state_r <= IDLE;
          end
        end
        WAIT: begin
          if (reg_response) begin
            if (grant_r) begin
              response1  <= 1'b1;
              read_data1 <= reg_read_data;
            end else begin
              response0  <= 1'b1;
              read_data0 <= reg_read_data;
            end
            state_r <= DONE;
          end else if (count_r == COUNT_LIMIT) begin
            if (grant_r) begin
              response1  <= 1'b1;
              error1     <= 1'b1;
              read_data1 <= 8'hFF;
            end else begin
              response0  <= 1'b1;
              error0     <= 1'b1;
              read_data0 <= 8'hFF;
            end
            state_r <= DONE;
          end else begin
            count_r <= count_r + COUNT_WIDTH'(1);
          end
        end
        DONE: begin
          // lock as presented during the response cycle decides ownership
          owner_valid_r <= done_lock_s;
          owner_r       <= grant_r;
          state_r       <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812b_reg_arbiter.sv
// Bench for ws2812b_reg_arbiter: scripted requester agents, a configurable
// register responder, a transaction-timing reference model checked every
// cycle, and directed scenarios with literal expectations.

module tb_ws2812b_reg_arbiter;

  localparam int AW = 2;
  localparam int T  = 16;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic          is_write0 = 1'b0, is_write1 = 1'b0;
  logic [AW-1:0] address0 = '0, address1 = '0;
  logic [7:0]    write_data0 = 8'h00, write_data1 = 8'h00;
  logic          lock0 = 1'b0, lock1 = 1'b0;
  logic          response0, response1, error0, error1;
  logic [7:0]    read_data0, read_data1;
  logic          reg_request, reg_is_write;
  logic [AW-1:0] reg_address;
  logic [7:0]    reg_write_data;
  logic          reg_response = 1'b0;
  logic [7:0]    reg_read_data = 8'h00;

  always #5 clock = ~clock;

  ws2812b_reg_arbiter #(.ADDRESS_WIDTH(AW), .TIMEOUT_CYCLES(T)) dut (
    .clock(clock), .resetn(resetn),
    .req0(req0), .is_write0(is_write0), .address0(address0), .write_data0(write_data0),
    .lock0(lock0), .response0(response0), .read_data0(read_data0), .error0(error0),
    .req1(req1), .is_write1(is_write1), .address1(address1), .write_data1(write_data1),
    .lock1(lock1), .response1(response1), .read_data1(read_data1), .error1(error1),
    .reg_request(reg_request), .reg_is_write(reg_is_write), .reg_address(reg_address),
    .reg_write_data(reg_write_data), .reg_response(reg_response), .reg_read_data(reg_read_data)
  );

  typedef struct {bit w; bit [AW-1:0] a; bit [7:0] d; bit lk; int gap;} xfer_t;
  typedef struct {int cyc; bit w; bit [AW-1:0] a; bit [7:0] d;} rq_t;
  typedef struct {int cyc; int port; bit [7:0] d; bit err;} rs_t;

  int ncmp = 0;
  int nfail = 0;
  int cyc = 0;
  int rst_cycles = 0;
  bit checking = 1'b0;

  // requester agents
  xfer_t q0[$], q1[$];
  xfer_t cur[2], nxt[2];
  bit    act[2], have_next[2], seen_resp[2];
  int    wait_c[2], pres_cyc[2];

  // responder controls
  int       rsp_mode = 0;   // 0 random, 1 fixed delay, 2 silent
  int       rsp_delay = 1;
  bit [7:0] rsp_data = 8'h00;
  bit       spurious_en = 1'b0;
  int       due = -1;
  int       inject_at = -1;
  bit [7:0] inject_data = 8'h00;

  // monitor logs
  rq_t rq_log[$];
  rs_t rs_log[$];
  bit  p1_activity = 1'b0;

  // reference model: expected outputs for the next cycle
  bit       m_busy;
  int       m_port, m_start, m_idle_from, m_done_at, m_owner, m_last;
  bit       e_rq, e_w, e_resp0, e_resp1, e_err0, e_err1;
  bit [AW-1:0] e_a;
  bit [7:0] e_d, e_rd0, e_rd1;

  function automatic xfer_t mk(bit w, bit [AW-1:0] a, bit [7:0] d, bit lk, int gap);
    xfer_t x;
    x.w = w; x.a = a; x.d = d; x.lk = lk; x.gap = gap;
    return x;
  endfunction

  task automatic chk(string name, logic [31:0] act_v, logic [31:0] exp_v);
    ncmp++;
    if (act_v !== exp_v) begin
      nfail++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act_v, exp_v);
    end
  endtask

  task automatic clear_logs();
    rq_log.delete();
    rs_log.delete();
    p1_activity = 1'b0;
  endtask

  task automatic agent_step(int p);
    if (seen_resp[p]) act[p] = 1'b0;
    if (!act[p] && !have_next[p]) begin
      if (p == 0 && q0.size() > 0) begin
        nxt[p] = q0.pop_front(); have_next[p] = 1'b1; wait_c[p] = nxt[p].gap;
      end else if (p == 1 && q1.size() > 0) begin
        nxt[p] = q1.pop_front(); have_next[p] = 1'b1; wait_c[p] = nxt[p].gap;
      end
    end
    if (!act[p] && have_next[p]) begin
      if (wait_c[p] == 0) begin
        cur[p] = nxt[p]; act[p] = 1'b1; have_next[p] = 1'b0; pres_cyc[p] = cyc;
      end else begin
        wait_c[p]--;
      end
    end
    seen_resp[p] = (p == 0) ? response0 : response1;
    if (p == 0) begin
      req0 = act[0]; is_write0 = cur[0].w; address0 = cur[0].a;
      write_data0 = cur[0].d; lock0 = cur[0].lk;
    end else begin
      req1 = act[1]; is_write1 = cur[1].w; address1 = cur[1].a;
      write_data1 = cur[1].d; lock1 = cur[1].lk;
    end
  endtask

  task automatic resp_step();
    if (reg_request) begin
      if (rsp_mode == 0) begin
        if ($urandom_range(0, 9) == 0) due = -1;
        else due = cyc + int'($urandom_range(0, 4));
      end else if (rsp_mode == 1) begin
        due = cyc + rsp_delay;
      end else begin
        due = -1;
      end
    end
    reg_response  = 1'b0;
    reg_read_data = 8'($urandom);
    if (due == cyc) begin
      reg_response = 1'b1;
      if (rsp_mode == 1) reg_read_data = rsp_data;
      due = -1;
    end else if (cyc == inject_at) begin
      reg_response  = 1'b1;
      reg_read_data = inject_data;
    end else if (spurious_en && $urandom_range(0, 24) == 0) begin
      reg_response = 1'b1;
    end
  endtask

  task automatic model_finish(bit [7:0] d, bit err);
    if (m_port == 0) begin e_resp0 = 1'b1; e_err0 = err; e_rd0 = d; end
    else             begin e_resp1 = 1'b1; e_err1 = err; e_rd1 = d; end
    m_busy = 1'b0;
    m_done_at = cyc + 1;
    m_idle_from = cyc + 2;
  endtask

  // Predicts the outputs of the next cycle from the inputs of this cycle.
  task automatic model_step();
    bit c0, c1;
    int g;
    e_rq = 1'b0; e_resp0 = 1'b0; e_resp1 = 1'b0; e_err0 = 1'b0; e_err1 = 1'b0;
    if (!resetn) begin
      e_w = 1'b0; e_a = '0; e_d = 8'h00; e_rd0 = 8'h00; e_rd1 = 8'h00;
      m_busy = 1'b0; m_owner = -1; m_last = 1; m_idle_from = 0; m_done_at = -1;
      checking = 1'b1;
      return;
    end
    if (cyc == m_done_at) m_owner = ((m_port == 0) ? lock0 : lock1) ? m_port : -1;
    if (m_busy) begin
      if (reg_response) model_finish(reg_read_data, 1'b0);
      else if (cyc - m_start == T + 1) model_finish(8'hFF, 1'b1);
    end else if (cyc >= m_idle_from) begin
      c0 = req0 && (m_owner != 1);
      c1 = req1 && (m_owner != 0);
      if (c0 || c1) begin
        if (c0 && c1) g = (m_last == 0) ? 1 : 0;
        else g = c0 ? 0 : 1;
        e_rq = 1'b1;
        e_w = (g == 0) ? is_write0 : is_write1;
        e_a = (g == 0) ? address0 : address1;
        e_d = (g == 0) ? write_data0 : write_data1;
        m_busy = 1'b1; m_port = g; m_start = cyc; m_last = g;
      end
    end
  endtask

  // One clock cycle: compare, log, drive stimulus, advance the model.
  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
    if (checking) begin
      chk("reg_request", reg_request, e_rq);
      chk("reg_is_write", reg_is_write, e_w);
      chk("reg_address", reg_address, e_a);
      chk("reg_write_data", reg_write_data, e_d);
      chk("response0", response0, e_resp0);
      chk("response1", response1, e_resp1);
      chk("error0", error0, e_err0);
      chk("error1", error1, e_err1);
      chk("read_data0", read_data0, e_rd0);
      chk("read_data1", read_data1, e_rd1);
    end
    if (reg_request) rq_log.push_back('{cyc, reg_is_write, reg_address, reg_write_data});
    if (response0) rs_log.push_back('{cyc, 0, read_data0, error0});
    if (response1) rs_log.push_back('{cyc, 1, read_data1, error1});
    if (response1 || error1 || read_data1 != 8'h00) p1_activity = 1'b1;
    if (rst_cycles > 0) begin
      resetn = 1'b0;
      rst_cycles--;
      q0.delete(); q1.delete();
      for (int p = 0; p < 2; p++) begin
        act[p] = 1'b0; have_next[p] = 1'b0; seen_resp[p] = 1'b0;
      end
      due = -1;
    end else begin
      resetn = 1'b1;
    end
    agent_step(0);
    agent_step(1);
    resp_step();
    model_step();
  endtask

  task automatic steps(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst_cycles = 2;
    steps(3);
    clear_logs();
    inject_at = -1;
  endtask

  initial begin
    int c;
    int n;

    // ---------- reset state ----------
    rsp_mode = 1; rsp_delay = 1; spurious_en = 1'b0;
    do_reset();
    chk("reset_response0", response0, 0);
    chk("reset_reg_request", reg_request, 0);
    chk("reset_read_data0", read_data0, 0);

    // ---------- single read, port 0 ----------
    rsp_data = 8'h5A;
    q0.push_back(mk(1'b0, 2'd3, 8'h00, 1'b0, 0));
    step();
    c = pres_cyc[0];
    steps(7);
    chk("sr_req_count", rq_log.size(), 1);
    if (rq_log.size() > 0) begin
      chk("sr_req_cycle", rq_log[0].cyc - c, 1);
      chk("sr_req_addr", rq_log[0].a, 3);
      chk("sr_req_write", rq_log[0].w, 0);
    end
    chk("sr_resp_count", rs_log.size(), 1);
    if (rs_log.size() > 0) begin
      chk("sr_resp_cycle", rs_log[0].cyc - c, 3);
      chk("sr_resp_port", rs_log[0].port, 0);
      chk("sr_resp_data", rs_log[0].d, 8'h5A);
      chk("sr_resp_err", rs_log[0].err, 0);
    end
    chk("sr_port1_quiet", p1_activity, 0);

    // ---------- tie after reset: 0,1,0,1 ----------
    do_reset();
    rsp_data = 8'h11;
    q0.push_back(mk(1'b0, 2'd0, 8'h00, 1'b0, 0));
    q0.push_back(mk(1'b0, 2'd1, 8'h00, 1'b0, 0));
    q1.push_back(mk(1'b0, 2'd2, 8'h00, 1'b0, 0));
    q1.push_back(mk(1'b0, 2'd3, 8'h00, 1'b0, 0));
    steps(20);
    chk("tie_resp_count", rs_log.size(), 4);
    if (rs_log.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("tie_order", rs_log[i].port, i % 2);
        if (i > 0) chk("tie_spacing", rs_log[i].cyc - rs_log[i-1].cyc, 4);
      end
    end

    // ---------- locked burst on port 1 ----------
    do_reset();
    q1.push_back(mk(1'b1, 2'd0, 8'h02, 1'b1, 0));
    q1.push_back(mk(1'b1, 2'd1, 8'h10, 1'b1, 0));
    q1.push_back(mk(1'b1, 2'd2, 8'h20, 1'b1, 0));
    q1.push_back(mk(1'b1, 2'd3, 8'h30, 1'b0, 0));
    q0.push_back(mk(1'b0, 2'd1, 8'h00, 1'b0, 1));
    steps(30);
    chk("lock_req_count", rq_log.size(), 5);
    if (rq_log.size() == 5) begin
      chk("lock_cmd", {rq_log[0].w, 6'(rq_log[0].a), rq_log[0].d}, {1'b1, 6'd0, 8'h02});
      chk("lock_r",   {rq_log[1].w, 6'(rq_log[1].a), rq_log[1].d}, {1'b1, 6'd1, 8'h10});
      chk("lock_g",   {rq_log[2].w, 6'(rq_log[2].a), rq_log[2].d}, {1'b1, 6'd2, 8'h20});
      chk("lock_b",   {rq_log[3].w, 6'(rq_log[3].a), rq_log[3].d}, {1'b1, 6'd3, 8'h30});
      chk("lock_p0",  {rq_log[4].w, 6'(rq_log[4].a)}, {1'b0, 6'd1});
    end
    chk("lock_resp_count", rs_log.size(), 5);
    if (rs_log.size() == 5) begin
      for (int i = 0; i < 5; i++) chk("lock_resp_port", rs_log[i].port, (i < 4) ? 1 : 0);
    end

    // ---------- timeout with a late response ----------
    do_reset();
    rsp_mode = 2;
    q0.push_back(mk(1'b0, 2'd2, 8'h00, 1'b0, 0));
    step();
    c = pres_cyc[0];
    inject_at = c + 20;
    inject_data = 8'h33;
    steps(25);
    chk("to_resp_count", rs_log.size(), 1);
    if (rs_log.size() > 0) begin
      chk("to_resp_cycle", rs_log[0].cyc - c, T + 2);
      chk("to_resp_err", rs_log[0].err, 1);
      chk("to_resp_data", rs_log[0].d, 8'hFF);
    end
    chk("to_late_ignored", read_data0, 8'hFF);

    // ---------- reset during WAIT ----------
    do_reset();
    q0.push_back(mk(1'b0, 2'd1, 8'h00, 1'b0, 0));
    steps(4);
    rst_cycles = 1;
    steps(2);
    chk("rw_response0", response0, 0);
    chk("rw_reg_request", reg_request, 0);
    chk("rw_reg_address", reg_address, 0);
    steps(20);
    chk("rw_no_response", rs_log.size(), 0);
    rsp_mode = 1;
    clear_logs();
    q0.push_back(mk(1'b0, 2'd0, 8'h00, 1'b0, 0));
    q1.push_back(mk(1'b0, 2'd3, 8'h00, 1'b0, 0));
    steps(10);
    chk("rw_tie_count", rs_log.size(), 2);
    if (rs_log.size() > 0) chk("rw_tie_first", rs_log[0].port, 0);

    // ---------- held request across DONE ----------
    do_reset();
    q0.push_back(mk(1'b0, 2'd2, 8'h00, 1'b0, 0));
    q0.push_back(mk(1'b0, 2'd2, 8'h00, 1'b0, 0));
    step();
    c = pres_cyc[0];
    steps(8);
    n = 0;
    foreach (rq_log[i]) if (rq_log[i].cyc > c && rq_log[i].cyc <= c + 8) n++;
    chk("held_req_count", n, 2);
    if (rq_log.size() > 1) chk("held_second_cycle", rq_log[1].cyc - c, 5);

    // ---------- randomized traffic ----------
    do_reset();
    rsp_mode = 0;
    spurious_en = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if (q0.size() == 0 && $urandom_range(0, 3) == 0)
        q0.push_back(mk(1'($urandom), AW'($urandom), 8'($urandom),
                        $urandom_range(0, 2) == 0, int'($urandom_range(0, 3))));
      if (q1.size() == 0 && $urandom_range(0, 3) == 0)
        q1.push_back(mk(1'($urandom), AW'($urandom), 8'($urandom),
                        $urandom_range(0, 2) == 0, int'($urandom_range(0, 3))));
      if ($urandom_range(0, 599) == 0) rst_cycles = 1;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/ws2812b_reg_arbiter.md
# ws2812b_reg_arbiter

Two-requester arbiter for the single register port of the WS2812B LED controller. It shares that port between the I2C register bridge (port 0) and an on-chip pattern engine (port 1). The LED register protocol is stateful: a COMMAND write selects the pixel, then R/G/B accesses apply to it. The arbiter therefore supports locked bursts, so that one requester's COMMAND→R/G/B sequence is never interleaved with the other's. It also guards against a missing downstream response with a timeout.

## Interface
Parameters
- ADDRESS_WIDTH, 2, width of register address (matches the LED controller's 4 registers)
- TIMEOUT_CYCLES, 16, cycles to wait for reg_response before aborting a transfer (≥2)

Ports
- clock  input  1  clock
- resetn  input  1  reset, synchronous, active-low
- req0 / req1  input  1  transfer request; held high with fields stable until matching response pulse
- is_write0 / is_write1  input  1  1 = write, 0 = read
- address0 / address1  input  ADDRESS_WIDTH  target register
- write_data0 / write_data1  input  8  write data
- lock0 / lock1  input  1  keep ownership after this transfer completes
- response0 / response1  output  1  one-cycle completion pulse
- read_data0 / read_data1  output  8  read data, valid while response pulse is high
- error0 / error1  output  1  high with the response pulse when the transfer timed out
- reg_request  output  1  one-cycle request pulse to the LED controller
- reg_is_write  output  1  downstream direction
- reg_address  output  ADDRESS_WIDTH  downstream address
- reg_write_data  output  8  downstream write data
- reg_response  input  1  downstream completion pulse
- reg_read_data  input  8  downstream read data

## Operation
- All outputs are registered. Reset value of every output is 0. Internal state on reset: state=IDLE, owner=none, last_grant=1 (so port 0 wins the first tie), timeout counter=0.
- States: IDLE, WAIT, DONE.
- IDLE, grant selection:
  - If an owner is locked, only that port's req is considered; the other port's req is ignored.
  - Otherwise, one requester → grant it.
  - Otherwise, both requesting → grant the port ≠ last_grant (round-robin).
  - On grant: latch is_write/address/write_data of the granted port onto reg_* outputs; pulse reg_request for exactly one cycle; clear the counter; set last_grant; go to WAIT.
- WAIT:
  - reg_request=0; reg_* fields held stable. The counter increments each cycle.
  - reg_response=1 → capture reg_read_data into read_dataN of the granted port; go to DONE with responseN=1, errorN=0.
  - Counter reaches TIMEOUT_CYCLES without reg_response → go to DONE with responseN=1, errorN=1, read_dataN=8'hFF.
- DONE (exactly one cycle):
  - responseN high; then it returns to 0 and the state goes to IDLE.
  - If lockN was high in the cycle response was issued, the owner stays N (locked); else owner=none.
  - req inputs are ignored in DONE, so a still-high req is not double-counted.
- read_dataN holds its last value between responses; errorN is 0 outside response pulses.
- A reg_response arriving in IDLE or DONE (late, after a timeout) is ignored and does not update read data.
- Lock is honoured after a timed-out transfer too; a requester releases ownership by completing a transfer with lock low.
- Reset mid-transfer: everything returns to reset values; no response is produced for the in-flight transfer.

## Timing
- req sampled high at end of cycle C (state IDLE) → reg_request high in C+1.
- An LED controller responding after one cycle gives reg_response in C+2 → responseN in C+3 → IDLE in C+4.
- Earliest next grant: req sampled at end of C+4. Back-to-back throughput is 1 transfer per 4 cycles.
- The requester may change fields or drop req from C+4. Fields must stay stable C through C+3.
- Timeout path: responseN/errorN asserted TIMEOUT_CYCLES+1 cycles after reg_request, i.e. C+TIMEOUT_CYCLES+2.
- Simultaneous req0/req1 in IDLE with no lock: exactly one grant per arbitration; the loser keeps req high and is granted on the next IDLE.

## Test plan
- Single read, port 0: req0, address0=3, responder returns 8'h5A one cycle later → reg_request in C+1, response0 in C+3 with read_data0=8'h5A; port 1 outputs stay 0.
- Tie after reset: req0 and req1 both high continuously, 4 transfers → grant order 0,1,0,1; each response pulse is exactly one cycle.
- Locked burst: port 1 writes COMMAND=2, R=8'h10, G=8'h20, B=8'h30 with lock1 high on the first 3 transfers and low on the 4th; req0 high throughout → downstream order is all 4 port-1 writes, then port 0's transfer.
- Timeout: TIMEOUT_CYCLES=16, responder silent → response0 with error0=1, read_data0=8'hFF at C+18. A late reg_response at C+20 is ignored.
- Reset mid-WAIT: resetn low for 1 cycle during WAIT → all outputs 0, no response pulse. Next tie grants port 0.
- Held req: port 0 keeps req0 high across DONE with unchanged fields → a second transfer starts at C+4, not C+3; exactly two reg_request pulses in 8 cycles.
